// File: rtl/wd_burst_pkg.sv
// Shared types and defaults for the write-data burst tracker.
package wd_burst_pkg;

  localparam int unsigned LEN_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } ch_state_e;

endpackage

// File: rtl/wd_burst_tracker_if.sv
// Per-channel W handshake, burst-length load and status bundle.
interface wd_burst_tracker_if
  import wd_burst_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned LEN_W  = LEN_W_DEFAULT
);

  logic [NUM_CH-1:0]       Valid_Signal;
  logic [NUM_CH-1:0]       Ready_Signal;
  logic [NUM_CH-1:0]       Last_Data;
  logic [NUM_CH-1:0]       Len_Load;
  logic [NUM_CH*LEN_W-1:0] Len_In;
  logic [NUM_CH-1:0]       HandShake_En;
  logic [NUM_CH-1:0]       Busy;
  logic [NUM_CH-1:0]       HandShake_Done;
  logic [NUM_CH-1:0]       Burst_Err;

  modport master (
    output Valid_Signal, Ready_Signal, Last_Data, Len_Load, Len_In, HandShake_En,
    input  Busy, HandShake_Done, Burst_Err
  );

  modport slave (
    input  Valid_Signal, Ready_Signal, Last_Data, Len_Load, Len_In, HandShake_En,
    output Busy, HandShake_Done, Burst_Err
  );

endinterface

// File: rtl/wd_burst_ch.sv
// One write-data channel: beat counter, WLAST check and done/error flags.
module wd_burst_ch
  import wd_burst_pkg::*;
#(
  parameter int unsigned LEN_W       = LEN_W_DEFAULT,
  parameter bit          DONE_STICKY = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             ready,
  input  logic             last,
  input  logic             len_load,
  input  logic [LEN_W-1:0] len_in,
  input  logic             hs_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  ch_state_e        state, state_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic             busy_n, done_n, err_n;
  logic             beat, rem_zero, term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      rem   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      busy  <= busy_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  // A terminating beat sets done/err even if the acknowledge arrives in the same cycle.
  always_comb begin
    state_n  = state;
    rem_n    = rem;
    done_n   = 1'b0;
    err_n    = err & ~hs_en;
    beat     = valid & ready;
    rem_zero = (rem == '0);
    term     = beat & (rem_zero | last);

    unique case (state)
      ST_IDLE: begin
        if (beat) err_n = 1'b1;
        if (len_load) begin
          state_n = ST_ACTIVE;
          rem_n   = len_in;
        end
      end
      ST_ACTIVE: begin
        if (term) begin
          done_n  = 1'b1;
          rem_n   = '0;
          state_n = DONE_STICKY ? ST_DONE : ST_IDLE;
          if (!(rem_zero && last)) err_n = 1'b1;
        end else if (beat) begin
          rem_n = rem - LEN_W'(1);
        end
      end
      ST_DONE: begin
        done_n = ~hs_en;
        if (hs_en) state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        rem_n   = '0;
        err_n   = 1'b0;
      end
    endcase

    busy_n = (state_n == ST_ACTIVE);
  end

endmodule

// File: rtl/wd_burst_tracker.sv
// Multi-channel W burst tracker: one independent wd_burst_ch per channel.
module wd_burst_tracker
  import wd_burst_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned LEN_W       = LEN_W_DEFAULT,
  parameter bit          DONE_STICKY = 1'b0
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  wd_burst_tracker_if.slave    bus
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    wd_burst_ch #(
      .LEN_W       (LEN_W),
      .DONE_STICKY (DONE_STICKY)
    ) u_ch (
      .clk      (ACLK),
      .rst      (ARESET),
      .valid    (bus.Valid_Signal[c]),
      .ready    (bus.Ready_Signal[c]),
      .last     (bus.Last_Data[c]),
      .len_load (bus.Len_Load[c]),
      .len_in   (bus.Len_In[c*LEN_W +: LEN_W]),
      .hs_en    (bus.HandShake_En[c]),
      .busy     (bus.Busy[c]),
      .done     (bus.HandShake_Done[c]),
      .err      (bus.Burst_Err[c])
    );
  end

endmodule

// File: tb/tb_wd_burst_tracker.sv
// Self-checking bench: pulse-mode 4-channel tracker and sticky-mode 2-channel tracker.
module tb_wd_burst_tracker;

  localparam int unsigned NCH = 4;
  localparam int unsigned SCH = 2;
  localparam int unsigned LW  = 8;

  typedef struct packed {
    logic [3:0] busy;
    logic [3:0] done;
    logic [3:0] err;
  } exp_t;

  typedef struct {
    logic [3:0]  v, r, l, ld;
    logic [31:0] len;
    logic [3:0]  hs;
    exp_t        e;
  } vec_t;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  wd_burst_tracker_if #(.NUM_CH(NCH), .LEN_W(LW)) pif ();
  wd_burst_tracker_if #(.NUM_CH(SCH), .LEN_W(LW)) sif ();

  wd_burst_tracker #(.NUM_CH(NCH), .LEN_W(LW), .DONE_STICKY(1'b0)) u_pulse (
    .ACLK(ACLK), .ARESET(ARESET), .bus(pif.slave)
  );
  wd_burst_tracker #(.NUM_CH(SCH), .LEN_W(LW), .DONE_STICKY(1'b1)) u_sticky (
    .ACLK(ACLK), .ARESET(ARESET), .bus(sif.slave)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  vec_t tbl[$];

  // Reference model of the pulse-mode channels.
  bit   m_act[NCH];
  int   m_rem[NCH];
  bit   m_done[NCH];
  bit   m_err[NCH];
  int   done_cnt[NCH];

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, expv);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_act[c] = 1'b0; m_rem[c] = 0; m_done[c] = 1'b0; m_err[c] = 1'b0; done_cnt[c] = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] v, r, l, ld, input logic [31:0] len,
                            input logic [3:0] hs, output exp_t e);
    bit beat;
    for (int c = 0; c < NCH; c++) begin
      beat = v[c] && r[c];
      if (m_act[c]) begin
        if (beat && (m_rem[c] == 0 || l[c])) begin
          m_done[c] = 1'b1;
          m_err[c]  = (m_err[c] && !hs[c]) || !(m_rem[c] == 0 && l[c]);
          m_act[c]  = 1'b0;
        end else begin
          if (beat) m_rem[c] = m_rem[c] - 1;
          m_done[c] = 1'b0;
          m_err[c]  = m_err[c] && !hs[c];
        end
      end else begin
        m_done[c] = 1'b0;
        m_err[c]  = beat || (m_err[c] && !hs[c]);
        if (ld[c]) begin
          m_act[c] = 1'b1;
          m_rem[c] = int'(len[c*8 +: 8]);
        end
      end
      e.busy[c] = m_act[c];
      e.done[c] = m_done[c];
      e.err[c]  = m_err[c];
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, r, l, ld, input logic [31:0] len,
                              input logic [3:0] hs, eb, ed, ee);
    vec_t t;
    t.v = v; t.r = r; t.l = l; t.ld = ld; t.len = len; t.hs = hs;
    t.e.busy = eb; t.e.done = ed; t.e.err = ee;
    return t;
  endfunction

  // One pulse-DUT cycle; expectation from the table or the model goes through the scoreboard.
  task automatic cyc(input logic [3:0] v, r, l, ld, input logic [31:0] len, input logic [3:0] hs,
                     input bit use_tbl, input exp_t te, input string name);
    exp_t me, got;
    pif.Valid_Signal = v; pif.Ready_Signal = r; pif.Last_Data = l;
    pif.Len_Load = ld; pif.Len_In = len; pif.HandShake_En = hs;
    model_step(v, r, l, ld, len, hs, me);
    exp_q.push_back(use_tbl ? te : me);
    @(posedge ACLK);
    #1;
    got = exp_q.pop_front();
    chk({name, "_busy"}, pif.Busy, got.busy);
    chk({name, "_done"}, pif.HandShake_Done, got.done);
    chk({name, "_err"},  pif.Burst_Err, got.err);
    for (int c = 0; c < NCH; c++) if (pif.HandShake_Done[c]) done_cnt[c]++;
  endtask

  task automatic mcyc(input logic [3:0] v, r, l, ld, input logic [31:0] len,
                      input logic [3:0] hs, input string name);
    exp_t dummy;
    dummy = '0;
    cyc(v, r, l, ld, len, hs, 1'b0, dummy, name);
  endtask

  task automatic scyc(input logic [1:0] v, r, l, ld, input logic [15:0] len, input logic [1:0] hs,
                      input logic [1:0] eb, ed, ee, input string name);
    exp_t e, got;
    sif.Valid_Signal = v; sif.Ready_Signal = r; sif.Last_Data = l;
    sif.Len_Load = ld; sif.Len_In = len; sif.HandShake_En = hs;
    e.busy = {2'b00, eb}; e.done = {2'b00, ed}; e.err = {2'b00, ee};
    exp_q.push_back(e);
    @(posedge ACLK);
    #1;
    got = exp_q.pop_front();
    chk({name, "_busy"}, {2'b00, sif.Busy}, got.busy);
    chk({name, "_done"}, {2'b00, sif.HandShake_Done}, got.done);
    chk({name, "_err"},  {2'b00, sif.Burst_Err}, got.err);
  endtask

  task automatic pidle();
    pif.Valid_Signal = '0; pif.Ready_Signal = '0; pif.Last_Data = '0;
    pif.Len_Load = '0; pif.Len_In = '0; pif.HandShake_En = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lens[NCH];
    int sent[NCH];
    logic [3:0] v, r, l;
    bit all_sent;

    ARESET = 1'b1;
    pidle();
    sif.Valid_Signal = '0; sif.Ready_Signal = '0; sif.Last_Data = '0;
    sif.Len_Load = '0; sif.Len_In = '0; sif.HandShake_En = '0;
    model_clear();
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_p_busy", pif.Busy, 4'h0);
    chk("rst_p_done", pif.HandShake_Done, 4'h0);
    chk("rst_p_err",  pif.Burst_Err, 4'h0);
    chk("rst_s_busy", {2'b00, sif.Busy}, 4'h0);
    chk("rst_s_done", {2'b00, sif.HandShake_Done}, 4'h0);
    chk("rst_s_err",  {2'b00, sif.Burst_Err}, 4'h0);
    ARESET = 1'b0;

    // Directed vectors with hand-derived expectations: {v, r, last, load, len, hs} -> {busy, done, err}.
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 4'h1, 32'h0000_0303, 4'h0, 4'h1, 4'h0, 4'h0));
    tbl.push_back(mk(4'h1, 4'h1, 4'h0, 4'h0, 32'h0000_0303, 4'h0, 4'h1, 4'h0, 4'h0));
    tbl.push_back(mk(4'h1, 4'h1, 4'h0, 4'h0, 32'h0000_0303, 4'h0, 4'h1, 4'h0, 4'h0));
    tbl.push_back(mk(4'h1, 4'h0, 4'h0, 4'h0, 32'h0000_0303, 4'h0, 4'h1, 4'h0, 4'h0));
    tbl.push_back(mk(4'h1, 4'h1, 4'h0, 4'h0, 32'h0000_0303, 4'h0, 4'h1, 4'h0, 4'h0));
    tbl.push_back(mk(4'h1, 4'h1, 4'h1, 4'h0, 32'h0000_0303, 4'h0, 4'h0, 4'h1, 4'h0));
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 32'h0000_0303, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 4'h2, 32'h0000_0303, 4'h0, 4'h2, 4'h0, 4'h0));
    tbl.push_back(mk(4'h2, 4'h2, 4'h0, 4'h0, 32'h0000_0303, 4'h0, 4'h2, 4'h0, 4'h0));
    tbl.push_back(mk(4'h2, 4'h2, 4'h2, 4'h0, 32'h0000_0303, 4'h0, 4'h0, 4'h2, 4'h2));
    tbl.push_back(mk(4'h2, 4'h2, 4'h2, 4'h0, 32'h0000_0303, 4'h0, 4'h0, 4'h0, 4'h2));
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 32'h0000_0303, 4'h2, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 4'h4, 32'h0000_0303, 4'h0, 4'h4, 4'h0, 4'h0));
    tbl.push_back(mk(4'h4, 4'h4, 4'h0, 4'h0, 32'h0000_0303, 4'h0, 4'h0, 4'h4, 4'h4));
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 4'h4, 32'h0000_0303, 4'h4, 4'h4, 4'h0, 4'h0));
    tbl.push_back(mk(4'h4, 4'h4, 4'h4, 4'h0, 32'h0000_0303, 4'h0, 4'h0, 4'h4, 4'h0));
    tbl.push_back(mk(4'h8, 4'h8, 4'h0, 4'h8, 32'h0000_0303, 4'h0, 4'h8, 4'h0, 4'h8));
    tbl.push_back(mk(4'h8, 4'h8, 4'h8, 4'h0, 32'h0000_0303, 4'h8, 4'h0, 4'h8, 4'h0));
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 4'h1, 32'h0000_0001, 4'h0, 4'h1, 4'h0, 4'h0));
    tbl.push_back(mk(4'h1, 4'h1, 4'h1, 4'h0, 32'h0000_0001, 4'h1, 4'h0, 4'h1, 4'h1));
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 4'h0, 4'h1));
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 32'h0000_0000, 4'h1, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(4'h0, 4'h0, 4'h0, 4'h2, 32'h0000_0100, 4'h0, 4'h2, 4'h0, 4'h0));
    tbl.push_back(mk(4'h2, 4'h2, 4'h0, 4'h2, 32'h0000_0500, 4'h0, 4'h2, 4'h0, 4'h0));
    tbl.push_back(mk(4'h2, 4'h2, 4'h2, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 4'h2, 4'h0));
    tbl.push_back(mk(4'h0, 4'h8, 4'h0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 4'h0, 4'h0));
    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].v, tbl[i].r, tbl[i].l, tbl[i].ld, tbl[i].len, tbl[i].hs, 1'b1, tbl[i].e,
          $sformatf("tbl%0d", i));

    // Staggered lengths 0/1/2/7 on all channels with random stalls.
    for (int c = 0; c < NCH; c++) begin done_cnt[c] = 0; sent[c] = 0; end
    lens[0] = 0; lens[1] = 1; lens[2] = 2; lens[3] = 7;
    mcyc(4'h0, 4'h0, 4'h0, 4'hF, {8'd7, 8'd2, 8'd1, 8'd0}, 4'h0, "stg_load");
    all_sent = 1'b0;
    for (int k = 0; k < 300 && !all_sent; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if (sent[c] <= lens[c]) begin
          v[c] = ($urandom_range(0, 3) != 0);
          r[c] = ($urandom_range(0, 2) != 0);
          l[c] = (sent[c] == lens[c]);
          if (v[c] && r[c]) sent[c]++;
        end else begin
          v[c] = 1'b0; r[c] = 1'b0; l[c] = 1'b0;
        end
      end
      mcyc(v, r, l, 4'h0, 32'h0, 4'h0, $sformatf("stg%0d", k));
      all_sent = 1'b1;
      for (int c = 0; c < NCH; c++) if (sent[c] <= lens[c]) all_sent = 1'b0;
    end
    for (int c = 0; c < NCH; c++) chk_int($sformatf("stg_done_count%0d", c), done_cnt[c], 1);

    // Maximum-length burst: AWLEN=255 on ch2, last on beat 256.
    for (int c = 0; c < NCH; c++) done_cnt[c] = 0;
    mcyc(4'h0, 4'h0, 4'h0, 4'h4, 32'h00FF_0000, 4'h0, "max_load");
    sent[2] = 0;
    for (int k = 0; k < 600 && sent[2] < 256; k++) begin
      v = {1'b0, ($urandom_range(0, 7) != 0), 2'b00};
      r = {1'b0, ($urandom_range(0, 7) != 0), 2'b00};
      l = {1'b0, (sent[2] == 255), 2'b00};
      if (v[2] && r[2]) sent[2]++;
      mcyc(v, r, l, 4'h0, 32'h0, 4'h0, "max_beat");
    end
    mcyc(4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 4'h0, "max_after");
    chk_int("max_done_count", done_cnt[2], 1);

    // Reset in the middle of a 4-beat burst on ch0.
    mcyc(4'h0, 4'h0, 4'h0, 4'h1, 32'h0000_0003, 4'h0, "rmid_load");
    mcyc(4'h1, 4'h1, 4'h0, 4'h0, 32'h0, 4'h0, "rmid_b1");
    mcyc(4'h1, 4'h1, 4'h0, 4'h0, 32'h0, 4'h0, "rmid_b2");
    pidle();
    ARESET = 1'b1;
    #1;
    chk("rmid_async_busy", pif.Busy, 4'h0);
    chk("rmid_async_done", pif.HandShake_Done, 4'h0);
    @(posedge ACLK);
    #3;
    ARESET = 1'b0;
    model_clear();
    @(posedge ACLK);
    #1;
    chk("rmid_post_done", pif.HandShake_Done, 4'h0);
    chk("rmid_post_err",  pif.Burst_Err, 4'h0);
    mcyc(4'h0, 4'h0, 4'h0, 4'h1, 32'h0000_0003, 4'h0, "rnew_load");
    for (int b = 0; b < 4; b++)
      mcyc(4'h1, 4'h1, (b == 3) ? 4'h1 : 4'h0, 4'h0, 32'h0, 4'h0, $sformatf("rnew_b%0d", b));
    mcyc(4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 4'h0, "rnew_after");
    chk_int("rnew_done_count", done_cnt[0], 1);
    pidle();

    // Sticky-mode channel: hold, ignored load/beats, acknowledge, reload.
    scyc(2'b00, 2'b00, 2'b00, 2'b01, 16'h0001, 2'b00, 2'b01, 2'b00, 2'b00, "s_load");
    scyc(2'b01, 2'b01, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b01, 2'b00, 2'b00, "s_b1");
    scyc(2'b01, 2'b01, 2'b01, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b01, 2'b00, "s_b2");
    for (int k = 0; k < 10; k++)
      scyc((k == 3) ? 2'b01 : 2'b00, (k == 3) ? 2'b01 : 2'b00, 2'b00, (k == 3) ? 2'b01 : 2'b00,
           16'h0005, 2'b00, 2'b00, 2'b01, 2'b00, $sformatf("s_hold%0d", k));
    scyc(2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 2'b01, 2'b00, 2'b00, 2'b00, "s_ack");
    scyc(2'b00, 2'b00, 2'b00, 2'b01, 16'h0000, 2'b00, 2'b01, 2'b00, 2'b00, "s_reload");
    scyc(2'b01, 2'b01, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b01, 2'b01, "s_nolast");
    scyc(2'b01, 2'b01, 2'b00, 2'b00, 16'h0000, 2'b01, 2'b00, 2'b00, 2'b00, "s_ack_beat");
    scyc(2'b10, 2'b10, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b10, "s_idle_beat1");
    scyc(2'b00, 2'b00, 2'b00, 2'b01, 16'h0000, 2'b00, 2'b01, 2'b00, 2'b10, "s_load2");
    scyc(2'b01, 2'b01, 2'b01, 2'b00, 16'h0000, 2'b10, 2'b00, 2'b01, 2'b00, "s_term_ack1");
    scyc(2'b00, 2'b00, 2'b00, 2'b01, 16'h0000, 2'b01, 2'b00, 2'b00, 2'b00, "s_ack_load");
    scyc(2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, "s_idle");
    scyc(2'b00, 2'b00, 2'b00, 2'b01, 16'h0000, 2'b00, 2'b01, 2'b00, 2'b00, "s_load3");
    scyc(2'b01, 2'b01, 2'b00, 2'b00, 16'h0000, 2'b01, 2'b00, 2'b01, 2'b01, "s_setwins");
    scyc(2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 2'b01, 2'b00, 2'b00, 2'b00, "s_final_ack");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
